sisc_fetch: RTL
===============

# sisc_fetch

Instruction fetch unit for the SISC processor: owns the program counter, reads 32-bit instruction words from instruction memory over a req/ack handshake, and presents a stable `ir` to the core. It drives the `ir` bus the core consumes. It accepts "next instruction" and branch-redirect requests from the control unit, and stops issuing fetches on a HALT opcode.

## Interface
- `AW`, 16, instruction address width (word addressed)
- `RESET_PC`, 0, PC value loaded on reset
- `HALT_OP`, 4'hF, opcode (`ir[31:28]`) that halts fetching
- `clk` input 1: single clock; all state updates on rising edge
- `rst_f` input 1: reset, synchronous, active-low
- `ir_load` input 1: core requests the next instruction; honoured only in HOLD
- `br_taken` input 1: with `ir_load`, redirect PC to `br_addr`
- `br_addr` input AW: branch target
- `mem_req` output 1: read request to instruction memory
- `mem_addr` output AW: read address, valid while `mem_req`=1
- `mem_ack` input 1: single-cycle pulse; `mem_rdata` valid in the same cycle
- `mem_rdata` input 32: instruction word
- `ir` output 32: current instruction, stable while `ir_valid`=1
- `ir_valid` output 1: `ir` holds a fetched instruction
- `pc` output AW: address of the next instruction to fetch
- `halted` output 1: HALT fetched; unit frozen until reset

## Operation
- States: FETCH, HOLD, HALT.
- Reset (`rst_f`=0 at an edge):
  - state=FETCH, `pc`=RESET_PC, `ir`=0, `ir_valid`=0, `mem_req`=0, `halted`=0.
  - Overrides every other input, including `mem_ack` in the same cycle.
- FETCH:
  - `mem_req`=1, `mem_addr`=`pc`, both held constant until `mem_ack` is sampled 1.
  - On ack: `ir`<=`mem_rdata`, `ir_valid`<=1, `pc`<=`pc`+1 (mod 2^AW; 0xFFFF wraps to 0), `mem_req`<=0.
  - If `mem_rdata[31:28]`==HALT_OP, next state is HALT; otherwise HOLD.
  - `ir_load` and `br_taken` are ignored in FETCH.
- HOLD:
  - `mem_req`=0; `ir` and `ir_valid` held.
  - On `ir_load`=1: `ir_valid`<=0, state<=FETCH.
    - If `br_taken`=1: `pc`<=`br_addr`; otherwise `pc` unchanged (already incremented).
  - `br_taken` without `ir_load` has no effect.
- HALT:
  - `halted`=1, `ir_valid`=1, `ir`=the HALT word, `mem_req`=0.
  - All inputs except reset are ignored.
- `mem_ack` while `mem_req`=0 is ignored; state and data are unchanged.
- `ir` never changes except on an accepted ack or on reset.

## Timing
- The first `mem_req` is asserted in the first cycle after `rst_f` is sampled high.
- Zero-wait memory (ack in cycle N, the cycle `mem_req` first rises): `ir`/`ir_valid` update at the end of N and are visible in N+1.
- `ir_load` in cycle M (HOLD): `ir_valid`=0 and `mem_req`=1 in cycle M+1, with `mem_addr` equal to the new `pc`.
- Best-case throughput: one instruction per 2 cycles.
- With W wait cycles, the fetch occupies W+1 cycles.
- No combinational path from any input to any output; all outputs are registered or decoded from state.
- Reset mid-fetch: `mem_req` deasserts at the edge where reset is sampled. An ack arriving later while `mem_req`=0 is dropped.

## Structure
- Shared package `sisc_pkg`:
  - opcode constants, including `OP_HALT`=4'hF
  - the state enum (FETCH/HOLD/HALT)
  - AW default and RESET_PC default
- Sub-module `sisc_pc`: AW-bit PC register with synchronous active-low reset, increment enable, load enable with load data; load takes priority over increment.
- The FSM and `ir` register live in `sisc_fetch`.
- The `ir` output connects directly to the core's `ir` input.

## Test plan
- Reset, zero-wait memory holding 0x11000001 at addr 0:
  - Cycle 1 after reset: `mem_req`=1, `mem_addr`=0.
  - Cycle 2: `ir`=0x11000001, `ir_valid`=1, `pc`=1.
- Wait states, ack 3 cycles after req:
  - `mem_addr` holds 0 for all 4 cycles.
  - `ir_valid` rises one cycle after the ack; `pc`=1.
- Branch: in HOLD with `pc`=5, pulse `ir_load`=1, `br_taken`=1, `br_addr`=0x0040:
  - Next cycle: `mem_req`=1, `mem_addr`=0x0040, `ir_valid`=0.
  - Repeat with `br_taken`=0: `mem_addr`=5.
- HALT: fetch 0xF0000000:
  - `halted`=1, `ir_valid`=1.
  - `ir_load` pulses produce no further `mem_req` for 20 cycles.
- Wrap and stray ack:
  - With `pc`=0xFFFF, a fetch completes and `pc` becomes 0x0000.
  - An ack pulse during HOLD leaves `ir` unchanged.
- Reset mid-fetch:
  - Drop `rst_f` while `mem_req`=1 and before the ack: next cycle `mem_req`=0, `ir`=0, `pc`=RESET_PC.
  - A late ack is ignored.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode map, fetch FSM states and fetch-unit defaults.
package sisc_pkg;

  localparam int AW_DEF       = 16;
  localparam int RESET_PC_DEF = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BR   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sisc_pc.sv
// Program counter register: load (branch) wins over increment (fetch complete).
module sisc_pc #(
  parameter int             AW       = 16,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          inc_en,
  input  logic          load_en,
  input  logic [AW-1:0] load_data,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= load_data;
    end else if (inc_en) begin
      pc_q <= pc_q + AW'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch unit: PC ownership, req/ack memory read, stable ir to the core.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
  parameter logic [3:0]    HALT_OP  = OP_HALT
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          ir_load,
  input  logic          br_taken,
  input  logic [AW-1:0] br_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   ir,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  fetch_state_e state, state_nx;
  logic         mem_req_q;
  logic [31:0]  ir_q;
  logic         ir_valid_q;
  logic         ack_ok;
  logic         pc_load;
  logic         hold_load;

  // An ack only counts while a request is actually outstanding; this drops
  // stray acks and acks that straggle in after a reset.
  assign ack_ok    = (state == ST_FETCH) && mem_req_q && mem_ack;
  assign hold_load = (state == ST_HOLD) && ir_load;

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_load  = 1'b0;
    unique case (state)
      ST_FETCH: begin
        if (ack_ok) begin
          state_nx = (mem_rdata[31:28] == HALT_OP) ? ST_HALT : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ir_load) begin
          state_nx = ST_FETCH;
          pc_load  = br_taken;
        end
      end
      ST_HALT: begin
        state_nx = ST_HALT;
      end
      default: begin
        state_nx = ST_FETCH;
      end
    endcase
  end

  // mem_req is registered from the next state so the first request appears
  // one cycle after reset is released and no input reaches it combinationally.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      mem_req_q  <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      mem_req_q <= (state_nx == ST_FETCH);
      if (ack_ok) begin
        ir_q       <= mem_rdata;
        ir_valid_q <= 1'b1;
      end else if (hold_load) begin
        ir_valid_q <= 1'b0;
      end
    end
  end

  sisc_pc #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_f     (rst_f),
    .inc_en    (ack_ok),
    .load_en   (pc_load),
    .load_data (br_addr),
    .pc        (pc)
  );

  assign mem_req  = mem_req_q;
  assign mem_addr = pc;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state == ST_HALT);

endmodule
